// File: rtl/board_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_reset_seq_pkg
// Description : Shared types and constants for the board power-up / reset
//               sequencer: state encoding, PLL-reset pulse length, default
//               delay settings and a saturating 8-bit counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package board_reset_seq_pkg;

    // Sequencer states; the encoding is visible on the seq_state output.
    typedef enum logic [2:0] {
        S_VCXO   = 3'd0,
        S_LOCK   = 3'd1,
        S_PHY    = 3'd2,
        S_REL    = 3'd3,
        S_RUN    = 3'd4,
        S_PLLRST = 3'd5
    } seq_state_e;

    // Length of the MMCM reset pulse issued after a lock-wait timeout.
    localparam int PLLRST_LEN = 16;

    // Default sequencing parameters for a typical carrier.
    localparam int DEF_N_DOM     = 4;
    localparam int DEF_DLY_W     = 16;
    localparam int DEF_VCXO_DLY  = 1000;
    localparam int DEF_PHY_DLY   = 2000;
    localparam int DEF_STAGGER   = 16;
    localparam int DEF_LOCK_FILT = 8;
    localparam int DEF_TIMEOUT   = 50000;

    // Increment an 8-bit event counter, sticking at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_reset_seq_lock.sv
`default_nettype none
// ============================================================================
// Module      : lock_filter
// Description : Brings the asynchronous MMCM lock indication into the
//               sequencer clock domain through a two-flop synchroniser and
//               only reports lock once it has been stable for LOCK_FILT
//               consecutive cycles. A single low sample drops lock_ok on the
//               next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_filter
    import board_reset_seq_pkg::*;
#(
    parameter int LOCK_FILT = DEF_LOCK_FILT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_ok
);

    // Run counter only needs to reach LOCK_FILT-1; it saturates there.
    localparam int c_run_w = (LOCK_FILT < 2) ? 1 : $clog2(LOCK_FILT);
    localparam logic [c_run_w-1:0] c_run_max = c_run_w'(LOCK_FILT - 1);

    logic               r_sync_meta;
    logic               r_sync;
    logic [c_run_w-1:0] r_run;
    logic               r_lock_ok;

    generate
        if (LOCK_FILT < 1) begin : g_err_lock_filt
            $error("lock_filter: LOCK_FILT must be at least 1");
        end
    endgenerate

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_sync      <= r_sync_meta;
        end
    end

    // Count consecutive high samples; lock is accepted on the LOCK_FILT-th.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= '0;
            r_lock_ok <= 1'b0;
        end else if (!r_sync) begin
            r_run     <= '0;
            r_lock_ok <= 1'b0;
        end else begin
            r_lock_ok <= (r_run == c_run_max);
            if (r_run != c_run_max) begin
                r_run <= r_run + c_run_w'(1);
            end
        end
    end

    assign lock_ok = r_lock_ok;

endmodule
`default_nettype wire

// File: rtl/board_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : board_reset_seq
// Description : Power-up and reset sequencer for carrier top levels. Enables
//               the VCXO, waits for filtered MMCM lock, pulses the Ethernet
//               PHY reset, then releases N_DOM domain resets in a fixed
//               staggered order. Lock loss re-sequences from the lock wait;
//               a software pulse re-sequences from the PHY reset.
//               Optional macro RSTSEQ_LOCK_TIMEOUT_EN adds a lock-wait
//               timeout that pulses pll_reset and a retry_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module board_reset_seq
    import board_reset_seq_pkg::*;
#(
    parameter int N_DOM     = DEF_N_DOM,
    parameter int DLY_W     = DEF_DLY_W,
    parameter int VCXO_DLY  = DEF_VCXO_DLY,
    parameter int PHY_DLY   = DEF_PHY_DLY,
    parameter int STAGGER   = DEF_STAGGER,
    parameter int LOCK_FILT = DEF_LOCK_FILT,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_reseq,
    output logic             vcxo_en,
    output logic             pll_reset,
    output logic             phy_rstn,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic             seq_done,
    output logic [2:0]       seq_state,
    output logic [7:0]       lock_loss_cnt
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    ,
    output logic [7:0]       retry_cnt
`endif
);

    localparam longint c_dly_lim = longint'(1) << DLY_W;

    localparam logic [DLY_W-1:0] c_vcxo_dly = DLY_W'(VCXO_DLY);
    localparam logic [DLY_W-1:0] c_phy_last = DLY_W'(PHY_DLY - 1);
    localparam logic [DLY_W-1:0] c_rel_end  = DLY_W'(STAGGER * N_DOM);
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    localparam logic [DLY_W-1:0] c_timeout     = DLY_W'(TIMEOUT);
    localparam logic [DLY_W-1:0] c_pllrst_last = DLY_W'(PLLRST_LEN - 1);
`endif

    // Every delay shares one counter, so each must fit its width.
    generate
        if (N_DOM < 1 || N_DOM > 16) begin : g_err_n_dom
            $error("board_reset_seq: N_DOM must be in 1..16");
        end
        if (DLY_W < 1 || DLY_W > 32) begin : g_err_dly_w
            $error("board_reset_seq: DLY_W must be in 1..32");
        end
        if (VCXO_DLY < 0 || VCXO_DLY >= c_dly_lim) begin : g_err_vcxo
            $error("board_reset_seq: VCXO_DLY does not fit DLY_W");
        end
        if (PHY_DLY < 1 || PHY_DLY >= c_dly_lim) begin : g_err_phy
            $error("board_reset_seq: PHY_DLY does not fit DLY_W");
        end
        if (STAGGER < 1 || STAGGER * N_DOM >= c_dly_lim) begin : g_err_stagger
            $error("board_reset_seq: STAGGER*N_DOM does not fit DLY_W");
        end
        if (TIMEOUT < 0 || TIMEOUT >= c_dly_lim) begin : g_err_timeout
            $error("board_reset_seq: TIMEOUT does not fit DLY_W");
        end
        if (PLLRST_LEN >= c_dly_lim) begin : g_err_pllrst
            $error("board_reset_seq: PLLRST_LEN does not fit DLY_W");
        end
    endgenerate

    seq_state_e       r_state;
    logic [DLY_W-1:0] r_cnt;
    logic             r_vcxo_en;
    logic             r_phy_rstn;
    logic [N_DOM-1:0] r_dom_rst_n;
    logic             r_seq_done;
    logic [7:0]       r_lock_loss_cnt;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    logic             r_pll_reset;
    logic [7:0]       r_retry_cnt;
`endif

    logic             w_lock_ok;
    logic             w_lock_lost;
    logic             w_reseq;
    logic [DLY_W-1:0] w_cnt_inc;
    logic [N_DOM-1:0] w_rel_hit;

    lock_filter #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .lock_ok    (w_lock_ok)
    );

    assign w_cnt_inc = r_cnt + DLY_W'(1);

    // Lock loss only matters once the PHY sequence has started.
    assign w_lock_lost = !w_lock_ok &&
                         (r_state == S_PHY || r_state == S_REL || r_state == S_RUN);
    assign w_reseq     = sw_reseq && (r_state == S_REL || r_state == S_RUN);

    // Domain i is released when the counter reaches STAGGER*(i+1).
    generate
        for (genvar g = 0; g < N_DOM; g++) begin : g_rel
            localparam logic [DLY_W-1:0] c_rel_at = DLY_W'(STAGGER * (g + 1));
            assign w_rel_hit[g] = (w_cnt_inc == c_rel_at);
        end
    endgenerate

    // Sequencer state machine with registered outputs; lock loss beats sw_reseq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_VCXO;
            r_cnt           <= '0;
            r_vcxo_en       <= 1'b0;
            r_phy_rstn      <= 1'b0;
            r_dom_rst_n     <= '0;
            r_seq_done      <= 1'b0;
            r_lock_loss_cnt <= 8'd0;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
            r_pll_reset     <= 1'b0;
            r_retry_cnt     <= 8'd0;
`endif
        end else begin
            r_vcxo_en <= 1'b1;
            if (w_lock_lost) begin
                r_state         <= S_LOCK;
                r_cnt           <= '0;
                r_phy_rstn      <= 1'b0;
                r_dom_rst_n     <= '0;
                r_seq_done      <= 1'b0;
                r_lock_loss_cnt <= sat_inc8(r_lock_loss_cnt);
            end else if (w_reseq) begin
                r_state     <= S_PHY;
                r_cnt       <= '0;
                r_phy_rstn  <= 1'b0;
                r_dom_rst_n <= '0;
                r_seq_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_VCXO: begin
                        if (r_cnt == c_vcxo_dly) begin
                            r_state <= S_LOCK;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_LOCK: begin
                        r_phy_rstn  <= 1'b0;
                        r_dom_rst_n <= '0;
                        r_seq_done  <= 1'b0;
                        if (w_lock_ok) begin
                            r_state <= S_PHY;
                            r_cnt   <= '0;
                        end
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
                        else if (r_cnt == c_timeout) begin
                            r_state     <= S_PLLRST;
                            r_cnt       <= '0;
                            r_pll_reset <= 1'b1;
                            r_retry_cnt <= sat_inc8(r_retry_cnt);
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
`endif
                    end
                    S_PHY: begin
                        if (r_cnt == c_phy_last) begin
                            r_state    <= S_REL;
                            r_cnt      <= '0;
                            r_phy_rstn <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_REL: begin
                        if (r_cnt == c_rel_end) begin
                            r_state    <= S_RUN;
                            r_cnt      <= '0;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_cnt       <= w_cnt_inc;
                            r_dom_rst_n <= r_dom_rst_n | w_rel_hit;
                        end
                    end
                    S_RUN: begin
                        r_seq_done <= 1'b1;
                    end
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
                    S_PLLRST: begin
                        if (r_cnt == c_pllrst_last) begin
                            r_state     <= S_LOCK;
                            r_cnt       <= '0;
                            r_pll_reset <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
`endif
                    default: begin
                        r_state     <= S_LOCK;
                        r_cnt       <= '0;
                        r_phy_rstn  <= 1'b0;
                        r_dom_rst_n <= '0;
                        r_seq_done  <= 1'b0;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
                        r_pll_reset <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

    assign vcxo_en       = r_vcxo_en;
    assign phy_rstn      = r_phy_rstn;
    assign dom_rst_n     = r_dom_rst_n;
    assign seq_done      = r_seq_done;
    assign seq_state     = r_state;
    assign lock_loss_cnt = r_lock_loss_cnt;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    assign pll_reset     = r_pll_reset;
    assign retry_cnt     = r_retry_cnt;
`else
    assign pll_reset     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_reset_seq
// Description : Directed self-checking bench for board_reset_seq with
//               N_DOM=3, VCXO_DLY=10, PHY_DLY=20, STAGGER=4, LOCK_FILT=3,
//               TIMEOUT=100. Covers power-up, lock glitch, lock filtering,
//               software re-sequence, priority and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_reset_seq;
    import board_reset_seq_pkg::*;

    localparam int N_DOM = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pll_locked;
    logic             sw_reseq;
    logic             vcxo_en;
    logic             pll_reset;
    logic             phy_rstn;
    logic [N_DOM-1:0] dom_rst_n;
    logic             seq_done;
    logic [2:0]       seq_state;
    logic [7:0]       lock_loss_cnt;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    logic [7:0]       retry_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    board_reset_seq #(
        .N_DOM     (N_DOM),
        .DLY_W     (16),
        .VCXO_DLY  (10),
        .PHY_DLY   (20),
        .STAGGER   (4),
        .LOCK_FILT (3),
        .TIMEOUT   (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .sw_reseq      (sw_reseq),
        .vcxo_en       (vcxo_en),
        .pll_reset     (pll_reset),
        .phy_rstn      (phy_rstn),
        .dom_rst_n     (dom_rst_n),
        .seq_done      (seq_done),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
        ,
        .retry_cnt     (retry_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Packed view: {state, vcxo_en, pll_reset, phy_rstn, dom_rst_n, seq_done}
    function automatic logic [9:0] obs();
        return {seq_state, vcxo_en, pll_reset, phy_rstn, dom_rst_n, seq_done};
    endfunction

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if (seq_state == target) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL %s_wait: state got %0d expected %0d", tag, seq_state, target);
        end
    endtask

    // Called on the first sample after S_PHY entry; follows the PHY hold
    // and the staggered domain release through to S_RUN.
    task automatic run_phy_to_run(input string tag);
        logic [9:0] exp;
        exp = {S_PHY, 7'b1_0_0_000_0};
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_phy_entry: got %b expected %b", tag, obs(), exp); end
        repeat (19) @(negedge clk);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_phy_hold: got %b expected %b", tag, obs(), exp); end
        @(negedge clk);
        exp = {S_REL, 7'b1_0_1_000_0};
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_phy_release: got %b expected %b", tag, obs(), exp); end
        repeat (3) @(negedge clk);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_rel_plus3: got %b expected %b", tag, obs(), exp); end
        @(negedge clk);
        exp = {S_REL, 7'b1_0_1_001_0};
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_rel_plus4: got %b expected %b", tag, obs(), exp); end
        repeat (4) @(negedge clk);
        exp = {S_REL, 7'b1_0_1_011_0};
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_rel_plus8: got %b expected %b", tag, obs(), exp); end
        repeat (4) @(negedge clk);
        exp = {S_REL, 7'b1_0_1_111_0};
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_rel_plus12: got %b expected %b", tag, obs(), exp); end
        @(negedge clk);
        exp = {S_RUN, 7'b1_0_1_111_1};
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL %s_run: got %b expected %b", tag, obs(), exp); end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        sw_reseq   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({obs(), lock_loss_cnt} !== {S_VCXO, 7'b0_0_0_000_0, 8'd0}) begin
            n_bad++; $display("FAIL reset_values: got %b expected %b", {obs(), lock_loss_cnt}, {S_VCXO, 15'd0});
        end
    endtask

    task automatic test_power_up();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (obs() !== {S_VCXO, 7'b1_0_0_000_0}) begin n_bad++; $display("FAIL vcxo_first_clock: got %b expected %b", obs(), {S_VCXO, 7'b1_0_0_000_0}); end
        repeat (9) @(negedge clk);
        n_cmp++; if (obs() !== {S_VCXO, 7'b1_0_0_000_0}) begin n_bad++; $display("FAIL vcxo_hold: got %b expected %b", obs(), {S_VCXO, 7'b1_0_0_000_0}); end
        @(negedge clk);
        n_cmp++; if (obs() !== {S_LOCK, 7'b1_0_0_000_0}) begin n_bad++; $display("FAIL vcxo_to_lock: got %b expected %b", obs(), {S_LOCK, 7'b1_0_0_000_0}); end
        wait_state(S_PHY, 20, "powerup");
        run_phy_to_run("powerup");
    endtask

    task automatic test_lock_glitch();
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        @(negedge clk);
        n_cmp++; if (obs() !== {S_RUN, 7'b1_0_1_111_1}) begin n_bad++; $display("FAIL glitch_pending: got %b expected %b", obs(), {S_RUN, 7'b1_0_1_111_1}); end
        @(negedge clk);
        n_cmp++;
        if ({obs(), lock_loss_cnt} !== {S_LOCK, 7'b1_0_0_000_0, 8'd1}) begin
            n_bad++; $display("FAIL glitch_drop: got %b expected %b", {obs(), lock_loss_cnt}, {S_LOCK, 7'b1_0_0_000_0, 8'd1});
        end
        wait_state(S_PHY, 20, "glitch");
        run_phy_to_run("glitch");
        n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL glitch_count: got %0d expected 1", lock_loss_cnt); end
    endtask

    task automatic test_sw_reseq();
        sw_reseq = 1'b1;
        @(negedge clk);
        sw_reseq = 1'b0;
        run_phy_to_run("swreseq");
        n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL swreseq_count: got %0d expected 1", lock_loss_cnt); end
    endtask

    task automatic test_priority();
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        sw_reseq = 1'b1;
        @(negedge clk);
        sw_reseq = 1'b0;
        n_cmp++;
        if ({obs(), lock_loss_cnt} !== {S_LOCK, 7'b1_0_0_000_0, 8'd2}) begin
            n_bad++; $display("FAIL priority: got %b expected %b", {obs(), lock_loss_cnt}, {S_LOCK, 7'b1_0_0_000_0, 8'd2});
        end
        pll_locked = 1'b1;
        wait_state(S_PHY, 20, "priority");
        run_phy_to_run("priority");
    endtask

    task automatic test_filter();
        bit left = 1'b0;
        pll_locked = 1'b0;
        wait_state(S_LOCK, 10, "filter_entry");
        n_cmp++; if (lock_loss_cnt !== 8'd3) begin n_bad++; $display("FAIL filter_count: got %0d expected 3", lock_loss_cnt); end
        for (int i = 0; i < 40; i++) begin
            pll_locked = ((i % 4) < 2);
            @(negedge clk);
            if (seq_state != S_LOCK) left = 1'b1;
        end
        n_cmp++; if (left !== 1'b0) begin n_bad++; $display("FAIL filter_toggle: left S_LOCK got %b expected 0", left); end
        pll_locked = 1'b0;
        @(negedge clk);
        sw_reseq = 1'b1;
        @(negedge clk);
        sw_reseq = 1'b0;
        n_cmp++; if (obs() !== {S_LOCK, 7'b1_0_0_000_0}) begin n_bad++; $display("FAIL sw_in_lock: got %b expected %b", obs(), {S_LOCK, 7'b1_0_0_000_0}); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({seq_state, lock_loss_cnt} !== {S_LOCK, 8'd3}) begin
            n_bad++; $display("FAIL sw_in_lock_later: got %b expected %b", {seq_state, lock_loss_cnt}, {S_LOCK, 8'd3});
        end
        pll_locked = 1'b1;
        wait_state(S_PHY, 20, "filter_recover");
        run_phy_to_run("filter_recover");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs(), lock_loss_cnt} !== {S_VCXO, 7'b0_0_0_000_0, 8'd0}) begin
            n_bad++; $display("FAIL async_reset: got %b expected %b", {obs(), lock_loss_cnt}, {S_VCXO, 15'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    task automatic test_lock_timeout();
        int  cnt;
        int  h;
        int  p;
        bit  hit;
        bit  fell;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0; hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            cnt++;
            if (pll_reset) hit = 1'b1;
        end
        n_cmp++;
        if ({16'(cnt), retry_cnt, seq_state} !== {16'd112, 8'd1, S_PLLRST}) begin
            n_bad++; $display("FAIL timeout_first: got cycles=%0d retry=%0d state=%0d expected 112 1 5", cnt, retry_cnt, seq_state);
        end
        for (int n = 2; n <= 3; n++) begin
            h = 1; p = 0; hit = 1'b0; fell = 1'b0;
            for (int k = 0; k < 300 && !hit; k++) begin
                @(negedge clk);
                p++;
                if (pll_reset) begin
                    if (fell) hit = 1'b1;
                    else h++;
                end else begin
                    fell = 1'b1;
                end
            end
            n_cmp++;
            if ({16'(h), 16'(p), retry_cnt} !== {16'd16, 16'd117, 8'(n)}) begin
                n_bad++; $display("FAIL timeout_pulse%0d: got high=%0d period=%0d retry=%0d expected 16 117 %0d", n, h, p, retry_cnt, n);
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (pll_reset !== 1'b1) begin n_bad++; $display("FAIL pllrst_mid_pulse: got %b expected 1", pll_reset); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pll_reset, retry_cnt, seq_state, vcxo_en} !== 13'd0) begin
            n_bad++; $display("FAIL pllrst_async_clear: got %b expected %b", {pll_reset, retry_cnt, seq_state, vcxo_en}, 13'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_sw_reseq();
        test_priority();
        test_filter();
        test_async_reset();
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
        test_lock_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/board_reset_seq.md
Name: board_reset_seq

Overview:
- Parametrised power-up and reset sequencer for carrier top levels; replaces hard-wired `VCXO_EN = 1`, free-running PHY reset and bare `clk_locked` fan-out.
- Enables the VCXO, waits for MMCM lock, holds and releases the Ethernet PHY reset, then releases N application clock-domain resets in a fixed staggered order.
- Detects MMCM lock loss at any time and re-sequences automatically.
- Accepts a software re-sequence pulse from the local bus.

Parameters:
- N_DOM, 4, number of staggered domain resets (1..16)
- DLY_W, 16, width of the shared delay counter
- VCXO_DLY, 1000, cycles from vcxo_en high to start of lock wait
- PHY_DLY, 2000, cycles phy_rstn is held low
- STAGGER, 16, cycles between successive domain releases
- LOCK_FILT, 8, consecutive synchronised-high cycles required to accept lock
- TIMEOUT, 50000, lock-wait timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  free-running sequencer clock (aux/board clock, not MMCM-derived)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  MMCM locked; asynchronous to clk, synchronised internally
- sw_reseq  in  1  one-cycle pulse requesting a full re-sequence
- vcxo_en  out  1  VCXO enable
- pll_reset  out  1  MMCM reset request
- phy_rstn  out  1  PHY reset, active low
- dom_rst_n  out  N_DOM  domain resets, active low; bit 0 is released first
- seq_done  out  1  high in RUN only
- seq_state  out  3  current state encoding
- lock_loss_cnt  out  8  saturating count of lock-loss events

Behaviour:
- Reset values: vcxo_en=0, pll_reset=0, phy_rstn=0, dom_rst_n=all 0, seq_done=0, seq_state=S_VCXO(0), lock_loss_cnt=0, counter=0.
- Lock filter: 2-FF synchroniser on pll_locked, then a saturating run counter. lock_ok=1 once the synchronised input has been high for LOCK_FILT consecutive cycles. Any synchronised low clears lock_ok the following cycle.
- S_VCXO (0): vcxo_en=1 from the first clock after rst_n deasserts and stays 1 thereafter. After VCXO_DLY cycles -> S_LOCK; counter is cleared on every transition.
- S_LOCK (1): all resets asserted. lock_ok -> S_PHY.
- S_PHY (2): phy_rstn=0 for exactly PHY_DLY cycles; phy_rstn rises on the transition -> S_REL.
- S_REL (3): dom_rst_n[i] rises exactly STAGGER*(i+1) cycles after entering S_REL. The cycle after bit N_DOM-1 rises -> S_RUN.
- S_RUN (4): seq_done=1; outputs held.
- Lock loss, in S_PHY, S_REL or S_RUN (lock_ok falls):
  - next cycle dom_rst_n=all 0 and seq_done=0;
  - phy_rstn=0;
  - lock_loss_cnt increments, saturating at 255;
  - state -> S_LOCK.
- sw_reseq:
  - honoured only in S_REL and S_RUN: next cycle phy_rstn=0, dom_rst_n=all 0, -> S_PHY;
  - ignored in all other states.
- Simultaneous lock loss and sw_reseq: lock loss wins.
- Counter arithmetic is unsigned DLY_W. Elaboration error if VCXO_DLY, PHY_DLY or STAGGER*N_DOM ≥ 2^DLY_W.
- Mid-operation rst_n assertion: all outputs return to their reset values immediately (asynchronously). Deassertion is synchronous-release by design.

Optional Feature:
- Macro RSTSEQ_LOCK_TIMEOUT_EN.
- Defined:
  - in S_LOCK, if lock_ok is not seen within TIMEOUT cycles -> S_PLLRST (5);
  - S_PLLRST drives pll_reset=1 for 16 cycles, then -> S_LOCK with the counter cleared;
  - adds output retry_cnt (8 bits, saturating, reset 0), incremented on each entry to S_PLLRST.
- Undefined: pll_reset tied 0, S_LOCK waits indefinitely, retry_cnt port absent.

Decomposition:
- Package board_reset_seq_pkg:
  - state enum {S_VCXO=0, S_LOCK=1, S_PHY=2, S_REL=3, S_RUN=4, S_PLLRST=5};
  - PLLRST_LEN=16;
  - default delay constants.
- Sub-module lock_filter: 2-FF synchroniser plus LOCK_FILT run counter; outputs lock_ok.

Test Plan:
- Bench parameters for all scenarios: N_DOM=3, VCXO_DLY=10, PHY_DLY=20, STAGGER=4, LOCK_FILT=3, TIMEOUT=100.
- Power-up: release rst_n, pll_locked high at cycle 0 -> vcxo_en=1 at cycle 1, phy_rstn rises 20 cycles after S_PHY entry, dom_rst_n steps 001/011/111 at +4/+8/+12, then seq_done=1.
- Lock glitch: 2-cycle pll_locked low pulse in S_RUN -> all dom_rst_n=0 within 4 cycles, lock_loss_cnt=1, full re-sequence through S_PHY completes.
- Filter: pll_locked toggling with period 4 in S_LOCK -> never leaves S_LOCK.
- Software re-sequence: sw_reseq pulse in S_RUN -> phy_rstn=0 next cycle, re-sequence completes, lock_loss_cnt unchanged. The same pulse in S_LOCK has no effect.
- Priority: sw_reseq coincident with lock loss -> state S_LOCK, not S_PHY, lock_loss_cnt incremented.
- RSTSEQ_LOCK_TIMEOUT_EN with pll_locked held low -> pll_reset 16-cycle pulse every 117 cycles, retry_cnt counts 1, 2, 3…; asserting rst_n mid-pulse clears pll_reset at once.
